// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter: one-hot + encoded grant, per-requester mask, zero-gap handoff.
// Optional time-quantum preemption when RR_QUANTUM_PREEMPT_EN is defined.
module rr_quantum_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned QUANTUM = 8,
  parameter int unsigned IDXW    = $clog2(WIDTH),
  parameter int unsigned CNTW    = $clog2(QUANTUM + 1)
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_request,
  input  logic [WIDTH-1:0] in_mask,
  output logic [WIDTH-1:0] out_grant,
  output logic [IDXW-1:0]  out_grant_idx,
  output logic             out_valid,
  output logic             out_preempt
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  if (WIDTH < 2 || QUANTUM < 1 || CNTW < 1) begin : g_bad_cfg
    $error("rr_quantum_arbiter: WIDTH must be >= 2 and QUANTUM >= 1");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_grant;
  logic [WIDTH-1:0] r_base;
  logic [IDXW-1:0]  r_idx;
  logic             r_valid;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_next_grant;
  logic [WIDTH-1:0] w_next_base;
  logic [IDXW-1:0]  w_next_idx;

  logic [WIDTH-1:0] w_req;
  logic [WIDTH-1:0] w_others;
  logic [WIDTH-1:0] w_rotl;
  logic [WIDTH-1:0] w_sel_base;
  logic [DW-1:0]    w_dreq;
  logic [DW-1:0]    w_ddiff;
  logic [DW-1:0]    w_dsel;
  logic [WIDTH-1:0] w_sel;

`ifdef RR_QUANTUM_PREEMPT_EN
  logic [CNTW-1:0]  r_cnt;
  logic             r_preempt;
  logic [CNTW-1:0]  w_next_cnt;
  logic             w_next_preempt;
`endif

  assign w_req    = in_request & in_mask;
  // Current grantee is excluded so a preemption always moves to someone else.
  assign w_others = w_req & ~r_grant;
  assign w_rotl   = {r_grant[WIDTH-2:0], r_grant[WIDTH-1]};

  assign w_sel_base = (r_state == S_HOLD) ? w_rotl : r_base;

  // First set bit at or above the base, wrapping, via double-width subtract-and-mask.
  assign w_dreq  = {w_others, w_others};
  assign w_ddiff = w_dreq - {{WIDTH{1'b0}}, w_sel_base};
  assign w_dsel  = w_dreq & ~w_ddiff;
  assign w_sel   = w_dsel[WIDTH-1:0] | w_dsel[DW-1:WIDTH];

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_base  = r_base;
`ifdef RR_QUANTUM_PREEMPT_EN
    w_next_cnt     = r_cnt;
    w_next_preempt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_next_grant = '0;
`ifdef RR_QUANTUM_PREEMPT_EN
        w_next_cnt = '0;
`endif
        if (w_req != '0) begin
          w_next_grant = w_sel;
          w_next_state = S_HOLD;
`ifdef RR_QUANTUM_PREEMPT_EN
          w_next_cnt = CNTW'(1);
`endif
        end
      end
      S_HOLD: begin
        if ((w_req & r_grant) == '0) begin
          w_next_base = w_rotl;
          if (w_others != '0) begin
            w_next_grant = w_sel;
`ifdef RR_QUANTUM_PREEMPT_EN
            w_next_cnt = CNTW'(1);
`endif
          end else begin
            w_next_grant = '0;
            w_next_state = S_IDLE;
`ifdef RR_QUANTUM_PREEMPT_EN
            w_next_cnt = '0;
`endif
          end
        end
`ifdef RR_QUANTUM_PREEMPT_EN
        else if (r_cnt == CNTW'(QUANTUM)) begin
          // Quantum spent: hand over if anyone waits, else restart the quantum.
          w_next_cnt = CNTW'(1);
          if (w_others != '0) begin
            w_next_base    = w_rotl;
            w_next_grant   = w_sel;
            w_next_preempt = 1'b1;
          end
        end else begin
          w_next_cnt = r_cnt + CNTW'(1);
        end
`endif
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_grant = '0;
      end
    endcase
  end

  always_comb begin
    w_next_idx = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (w_next_grant[i]) w_next_idx = w_next_idx | IDXW'(i);
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_base  <= WIDTH'(1);
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_base  <= w_next_base;
      r_idx   <= w_next_idx;
      r_valid <= (w_next_grant != '0);
    end
  end

`ifdef RR_QUANTUM_PREEMPT_EN
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_cnt     <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_cnt     <= w_next_cnt;
      r_preempt <= w_next_preempt;
    end
  end

  assign out_preempt = r_preempt;
`else
  assign out_preempt = 1'b0;
`endif

  assign out_grant     = r_grant;
  assign out_grant_idx = r_idx;
  assign out_valid     = r_valid;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Self-checking bench for rr_quantum_arbiter (WIDTH=4, QUANTUM=3): directed scenarios
// plus randomized traffic against an index-based round-robin reference model.
module tb_rr_quantum_arbiter;

  localparam int W = 4;
  localparam int Q = 3;
`ifdef RR_QUANTUM_PREEMPT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic         in_clk = 1'b0;
  logic         in_reset;
  logic [W-1:0] in_request;
  logic [W-1:0] in_mask;
  logic [W-1:0] out_grant;
  logic [1:0]   out_grant_idx;
  logic         out_valid;
  logic         out_preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: grantee index (-1 idle), base index, hold count.
  int m_gnt;
  int m_base;
  int m_cnt;
  bit m_pre;

  rr_quantum_arbiter #(.WIDTH(W), .QUANTUM(Q)) dut (
    .in_clk        (in_clk),
    .in_reset      (in_reset),
    .in_request    (in_request),
    .in_mask       (in_mask),
    .out_grant     (out_grant),
    .out_grant_idx (out_grant_idx),
    .out_valid     (out_valid),
    .out_preempt   (out_preempt)
  );

  always #5 in_clk = ~in_clk;

  function automatic int next_from(int start, logic [W-1:0] req, int excl);
    for (int k = 0; k < W; k++) begin
      int j;
      j = (start + k) % W;
      if (req[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_vec(int g);
    logic [W-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_base = 0; m_cnt = 0; m_pre = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] req;
    int n;
    req   = in_request & in_mask;
    m_pre = 1'b0;
    if (m_gnt < 0) begin
      if (req != '0) begin
        m_gnt = next_from(m_base, req, -1);
        m_cnt = 1;
      end else m_cnt = 0;
    end else if (!req[m_gnt]) begin
      m_base = (m_gnt + 1) % W;
      n = next_from(m_base, req, m_gnt);
      m_gnt = n;
      m_cnt = (n < 0) ? 0 : 1;
    end else if (QEN && m_cnt == Q) begin
      n = next_from((m_gnt + 1) % W, req, m_gnt);
      if (n >= 0) begin
        m_base = (m_gnt + 1) % W;
        m_gnt  = n;
        m_pre  = 1'b1;
      end
      m_cnt = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Advance one clock edge, update the model, and leave time at edge+1.
  task automatic tick();
    @(posedge in_clk);
    if (in_reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    in_reset = 1'b1; in_request = '0; in_mask = '1;
    model_reset();
    @(posedge in_clk); @(posedge in_clk); #1;
    n_checks++;
    if ({out_grant, out_grant_idx, out_valid, out_preempt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b idx=%0d valid=%b pre=%b, want all 0",
               out_grant, out_grant_idx, out_valid, out_preempt);
    end
    @(negedge in_clk);
    in_reset = 1'b0;
  endtask

  task automatic test_single();
    test_reset();
    in_request = 4'b0100;
    tick();
    n_checks++;
    if (out_grant !== 4'b0100 || out_grant_idx !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b idx=%0d valid=%b, want 0100/2/1",
               out_grant, out_grant_idx, out_valid);
    end
    in_request = '0;
    tick();
    n_checks++;
    if (out_grant !== 4'b0000 || out_grant_idx !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b idx=%0d valid=%b, want 0000/0/0",
               out_grant, out_grant_idx, out_valid);
    end
  endtask

  task automatic test_quantum();
    logic [W-1:0] exp_g [10];
    logic         exp_p [10];
    test_reset();
    in_request = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      exp_g[c] = 4'b0010; exp_p[c] = 1'b0;
    end
    if (QEN) begin
      exp_g[3] = 4'b1000; exp_p[3] = 1'b1;
      exp_g[4] = 4'b1000;
      exp_g[5] = 4'b1000;
      exp_p[6] = 1'b1;
      exp_g[9] = 4'b1000; exp_p[9] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (out_grant !== exp_g[c] || out_preempt !== exp_p[c]) begin
        n_fail++;
        $display("FAIL quantum_cycle%0d: got grant=%b pre=%b, want grant=%b pre=%b",
                 c, out_grant, out_preempt, exp_g[c], exp_p[c]);
      end
    end
    in_request = '0;
    tick();
  endtask

  task automatic test_zero_gap();
    test_reset();
    in_request = 4'b1001;
    tick();
    n_checks++;
    if (out_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_gap_first: got grant=%b, want 0001", out_grant);
    end
    in_request = 4'b1000;
    tick();
    n_checks++;
    if (out_grant !== 4'b1000 || out_valid !== 1'b1 || out_grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL zero_gap_handoff: got grant=%b idx=%0d valid=%b, want 1000/3/1",
               out_grant, out_grant_idx, out_valid);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    in_request = 4'b1000;
    tick();
    in_request = 4'b1001;
    tick();
    n_checks++;
    if (out_grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_hold: got grant=%b, want 1000", out_grant);
    end
    in_request = 4'b0001;
    tick();
    n_checks++;
    if (out_grant !== 4'b0001 || out_grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_handoff: got grant=%b idx=%0d, want 0001/0", out_grant, out_grant_idx);
    end
    // Base is now bit 0: releasing 0001 with 1010 waiting must pick bit 1, not bit 3.
    in_request = 4'b1010;
    tick();
    n_checks++;
    if (out_grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_base: got grant=%b, want 0010", out_grant);
    end
  endtask

  task automatic test_mask();
    test_reset();
    in_request = 4'b0100;
    tick();
    in_request = 4'b0110;
    tick();
    n_checks++;
    if (out_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mask_hold: got grant=%b, want 0100", out_grant);
    end
    in_mask = 4'b1011;
    tick();
    n_checks++;
    if (out_grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL mask_release: got grant=%b, want 0010", out_grant);
    end
    in_mask = 4'b0000;
    tick();
    n_checks++;
    if (out_grant !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_all: got grant=%b valid=%b, want 0000/0", out_grant, out_valid);
    end
    in_mask = '1;
    in_request = '0;
    tick();
  endtask

  task automatic test_async_reset();
    test_reset();
    in_request = 4'b0110;
    tick();
    tick();
    #2;
    in_reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({out_grant, out_grant_idx, out_valid, out_preempt} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got grant=%b idx=%0d valid=%b pre=%b, want all 0",
               out_grant, out_grant_idx, out_valid, out_preempt);
    end
    @(negedge in_clk);
    in_reset   = 1'b0;
    in_request = 4'b1111;
    tick();
    n_checks++;
    if (out_grant !== 4'b0001 || out_grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_base: got grant=%b idx=%0d, want 0001/0", out_grant, out_grant_idx);
    end
    in_request = '0;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] eg;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      // Keep the current grantee requesting most of the time so long holds occur.
      in_request = W'($urandom);
      if (m_gnt >= 0 && $urandom_range(0, 3) != 0) in_request[m_gnt] = 1'b1;
      in_mask = ($urandom_range(0, 7) == 0) ? W'($urandom) : '1;
      tick();
      eg = exp_vec(m_gnt);
      n_checks++;
      if (out_grant !== eg || out_valid !== (m_gnt >= 0) ||
          out_grant_idx !== 2'((m_gnt < 0) ? 0 : m_gnt) || out_preempt !== m_pre) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got grant=%b idx=%0d valid=%b pre=%b, want grant=%b pre=%b",
                 c, out_grant, out_grant_idx, out_valid, out_preempt, eg, m_pre);
      end
    end
    in_request = '0;
    in_mask    = '1;
    tick();
  endtask

  initial begin
    in_reset   = 1'b1;
    in_request = '0;
    in_mask    = '1;
    model_reset();
    test_reset();
    test_single();
    test_quantum();
    test_zero_gap();
    test_wrap();
    test_mask();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_quantum_arbiter.md
# rr_quantum_arbiter

Parametrised round-robin arbiter with one-hot and encoded grant outputs, a per-requester mask, zero-gap handoff between requesters, and optional time-quantum preemption. It sits in the Coprocessor between the requesting units and the shared execution resource. It is the successor to the current fixed-width round-robin arbiter, which idles one cycle between grants and never preempts.

## Interface
- WIDTH, 4, number of requesters (≥2)
- QUANTUM, 8, max consecutive cycles one requester holds the grant while others wait (≥1; used only with quantum enabled)
- IDXW, $clog2(WIDTH), width of encoded grant index
- CNTW, $clog2(QUANTUM+1), hold-counter width

- in_clk  input  1  clock, all state updates on rising edge
- in_reset  input  1  asynchronous, active-high reset
- in_request  input  WIDTH  request vector; bit i high = requester i wants the resource
- in_mask  input  WIDTH  enable vector; bit i low = requester i ignored (effective request = in_request & in_mask)
- out_grant  output  WIDTH  registered one-hot grant, all-zero when idle
- out_grant_idx  output  IDXW  index of the granted requester; 0 when idle
- out_valid  output  1  high when out_grant is non-zero
- out_preempt  output  1  one-cycle pulse, high in the cycle after a quantum preemption (quantum builds only; tied 0 otherwise)

## Operation
- Effective request: req = in_request & in_mask.
- Round-robin base pointer r_base is one-hot. Selection picks the first set bit of req at or above r_base, wrapping to bit 0. Implement this as a double-width vector using the subtract-and-mask method.
- The FSM has two states: IDLE and HOLD.
- IDLE:
  - out_grant = 0, r_cnt = 0.
  - If req ≠ 0: grant the selected requester, set r_cnt = 1, go to HOLD. Otherwise stay in IDLE.
- HOLD, grantee g:
  - Release: req[g] = 0, including when the mask is dropped. Set r_base to rotl(onehot g).
    - If req has other bits set, grant the next requester after g in the same edge, set r_cnt = 1, stay in HOLD (zero-gap handoff).
    - Otherwise set out_grant = 0 and go to IDLE.
  - Preempt (quantum builds): req[g] = 1, r_cnt == QUANTUM, and (req & ~onehot g) ≠ 0.
    - Set r_base to rotl(onehot g), grant the next requester, set r_cnt = 1, and pulse out_preempt.
  - Quantum expires with no other requester waiting: keep the grant and reload r_cnt = 1.
  - Otherwise hold the grant and set r_cnt = r_cnt + 1. The counter never exceeds QUANTUM.
- rotl wraps: bit WIDTH-1 rotates to bit 0.
- out_grant has at most one bit set at all times, and never grants a requester whose effective request was low on the deciding edge.
- out_grant_idx and out_valid are registered together with out_grant, so all three are consistent in every cycle.

## Timing
- Reset, asynchronous and applied immediately, even mid-HOLD:
  - State = IDLE, r_base = 1, r_cnt = 0.
  - out_grant = 0, out_grant_idx = 0, out_valid = 0, out_preempt = 0.
- Grant latency: a request sampled at edge N while idle gives out_grant valid after edge N (1 cycle).
- Handoff latency: a grantee dropping its request before edge N gives the next grant after edge N, with no idle cycle.
- Preemption: the grantee holds for exactly QUANTUM cycles. The new grant and out_preempt appear on the following cycle.
- Simultaneous requests from idle: the first bit at or above r_base wins. After reset that is the lowest index.
- Releasing the mask bit of the grantee acts as a release on the next edge.

## Configuration
- RR_QUANTUM_PREEMPT_EN defined:
  - r_cnt counts hold cycles.
  - Preemption at QUANTUM is active.
  - out_preempt is driven.
- RR_QUANTUM_PREEMPT_EN undefined:
  - No hold counter is built; the grant is held until the grantee releases.
  - out_preempt is tied to 0.
  - QUANTUM is ignored.

## Test plan
All scenarios use WIDTH=4, QUANTUM=3, in_mask=4'b1111 unless noted.
- Reset, then request 4'b0100 -> out_grant=0100, idx=2, valid=1 one cycle later. Drop the request -> grant 0 and valid 0 on the next cycle, then IDLE.
- From reset, request 4'b1010 held -> grant 0010.
  - Quantum build: grant 1000 after 3 cycles with out_preempt pulse, then back to 0010 after 3 more cycles.
  - Non-quantum build: 0010 is held indefinitely.
- Zero gap: grant on 0001 with request 1001. Drop bit 0 -> out_grant=1000 on the very next cycle, no idle cycle.
- Wrap: grant on 1000 with request 1001. Release bit 3 -> grant 0001, and r_base wraps to bit 0.
- Mask: grant on 0100 with request 0110. Clear in_mask bit 2 -> grant moves to 0010 on the next edge. Mask every requester -> IDLE.
- Assert in_reset asynchronously mid-HOLD, between clock edges -> all outputs 0 immediately. Deassert with request 1111 -> grant 0001 (base restored to 1).
